smvm_stream_tx: RTL and testbench
=================================

// Module: smvm_stream_tx
// PURPOSE
// Transmit end of the SMVM input stream. On a start command it reads a dense vector and a dense
// row-major matrix from a 1-cycle-latency SRAM and emits the SMVM stream: header beat, every vector
// element, then the non-zero matrix entries only, with column index and row-start flag (ipv).
// It sits between the host-loaded operand SRAM and the SMVM core's val/col/ipv inputs.
// PARAMETERS
// ADDR_W   15     SRAM address width
// VEC_BASE 0      SRAM address of vector element 0
// MAT_BASE 128    SRAM address of matrix element (0,0); element (r,c) at MAT_BASE + r*cols + c
// DIM_MAX  128    maximum legal rows and cols
// PORTS
// clk        in   1       clock, rising edge
// rst_n      in   1       asynchronous reset, active low
// start      in   1       command strobe; accepted only when busy=0
// rows_cfg   in   8       matrix rows, 1..DIM_MAX
// cols_cfg   in   8       matrix cols (= vector length), 1..DIM_MAX
// busy       out  1       command in progress
// done       out  1       1-cycle pulse after the last beat is accepted
// err        out  1       1-cycle pulse: start rejected (rows_cfg or cols_cfg is 0 or > DIM_MAX)
// mem_rd_en  out  1       SRAM read strobe
// mem_addr   out  ADDR_W  SRAM read address
// mem_rdata  in   8       SRAM read data, valid the cycle after mem_rd_en
// tx_valid   out  1       beat valid
// tx_ready   in   1       downstream accepts beat (handshake = tx_valid & tx_ready)
// tx_val     out  8       header: rows; vector: element; matrix: signed non-zero value
// tx_col     out  8       header: cols; vector: index; matrix: column index
// tx_ipv     out  1       matrix beat only: 1 = first beat of a new row
// tx_last    out  1       final beat of the command
// BEHAVIOUR
// - Reset: busy, done, err, mem_rd_en, tx_valid, tx_ipv, tx_last = 0; tx_val, tx_col, mem_addr = 0;
//   FIFO emptied, in-flight read discarded, FSM -> IDLE. Reset mid-command abandons it silently.
// - FSM: IDLE -(start, legal)-> HDR -> VEC -> MAT -> DRAIN -> IDLE. Illegal start: err pulse next
//   cycle, stay IDLE. start while busy is ignored (no err).
// - busy rises the cycle after an accepted start and falls together with the done pulse.
// - HDR: pushes one beat {val=rows, col=cols, ipv=0, last=0}; no SRAM read.
// - VEC: reads VEC_BASE+i for i=0..cols-1 in order; every element pushed, zeros included:
//   {val=data, col=i, ipv=0, last=0}.
// - MAT: reads r=0..rows-1, c=0..cols-1 in order; returned data != 0 pushed as {val, col=c,
//   ipv=(first push of row r)}; zero data dropped. An all-zero row pushes one marker
//   {val=0, col=0, ipv=1}. Row r's marker/push decision is made when data for (r,cols-1) returns.
// - tx_last=1 only on the final matrix beat (last non-zero or empty-row marker of row rows-1).
// - Output: 2-entry FIFO; head drives tx_*. tx_valid = FIFO non-empty. Beats never reorder or
//   change while tx_valid & !tx_ready. Gaps (tx_valid=0) are legal mid-stream, e.g. zero runs.
// - Read throttle: issue read only when occupancy + reads_in_flight - pop_this_cycle < 2;
//   at most 1 read in flight. With tx_ready=1 and dense data, 1 beat per cycle sustained.
// - Latency: start sampled at edge 0 -> header tx_valid at cycle 1; first vector read cycle 1,
//   first vector beat valid cycle 3 earliest.
// - DRAIN: all reads issued; wait for FIFO empty, then done pulse, busy=0, -> IDLE.
// - Address arithmetic: r*cols+c held as running counter (add cols per row), no multiplier;
//   width ADDR_W, no wrap for legal dims.
// - tx_val is raw SRAM byte (two's complement); no arithmetic applied.
// TESTING
// - rows=2, cols=3, vec={1,0,-2}, mat={{0,5,0},{7,0,-1}}, tx_ready=1 -> beats (2,3,0),(1,0,0),(0,1,0),
//   (-2,2,0),(5,1,ipv1),(7,0,ipv1),(-1,2,ipv0,last); done 1 cycle after last handshake.
// - Same matrix with row 0 all zero -> marker (0,0,ipv1) then row 1 beats; all-zero matrix
//   rows=3 -> three markers, last marker tx_last=1.
// - tx_ready toggled randomly (50%) on 16x16 random matrix -> beat sequence identical to ready=1
//   run, no beat changes while stalled, <=1 read in flight, FIFO never >2.
// - start with rows_cfg=0, then cols_cfg=200 -> err pulse each, busy stays 0, no SRAM reads;
//   start during busy -> ignored, stream unchanged.
// - 128x128 dense non-zero, tx_ready=1 -> 1+128+16384 beats, one per cycle after fill.
// - rst_n low mid-MAT -> all outputs reset values immediately; new start after release
//   produces complete fresh stream beginning with header.

Source files
------------

// File: rtl/smvm_stream_tx_if.sv
// smvm_stream_tx_if: SMVM input-stream beat bus between the transmit block and the SMVM core.
//   tx_valid  beat valid (master -> slave)
//   tx_ready  slave accepts beat; handshake = tx_valid & tx_ready
//   tx_val    header: rows; vector: element; matrix: signed non-zero value
//   tx_col    header: cols; vector: index; matrix: column index
//   tx_ipv    matrix beats only: first beat of a new row
//   tx_last   final beat of the command
interface smvm_stream_tx_if;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] tx_val;
    logic [7:0] tx_col;
    logic       tx_ipv;
    logic       tx_last;
    modport master (output tx_valid, tx_val, tx_col, tx_ipv, tx_last, input tx_ready);
    modport slave  (input tx_valid, tx_val, tx_col, tx_ipv, tx_last, output tx_ready);
endinterface

// File: rtl/smvm_stream_tx.sv
// smvm_stream_tx: reads a dense vector and row-major matrix from a 1-cycle SRAM and emits the SMVM stream.
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   start                 command strobe, accepted only while idle
//   rows_cfg, cols_cfg    matrix dimensions, legal range 1..DIM_MAX
//   busy, done, err       command in progress / completion pulse / rejected-start pulse
//   mem_rd_en, mem_addr   SRAM read request; mem_rdata returns the cycle after mem_rd_en
//   tx                    stream beat bus (master side)
module smvm_stream_tx #(
    parameter int ADDR_W   = 15,
    parameter int VEC_BASE = 0,
    parameter int MAT_BASE = 128,
    parameter int DIM_MAX  = 128
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [7:0]        rows_cfg,
    input  logic [7:0]        cols_cfg,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    smvm_stream_tx_if.master  tx
);
    typedef enum logic [2:0] {IDLE, HDR, VEC, MAT, DRAIN} state_t;
    typedef struct packed {
        logic [7:0] val;
        logic [7:0] col;
        logic       ipv;
        logic       last;
    } beat_t;

    state_t            state_q, state_d;
    beat_t             fifo_q [2];
    beat_t             fifo_d [2];
    logic              wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [7:0]        rows_q, rows_d, cols_q, cols_d, c_q, c_d, r_q, r_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic              rv_q, rv_d, rmat_q, rmat_d, rlc_q, rlc_d;
    logic [7:0]        rcol_q, rcol_d;
    logic              row_nz_q, row_nz_d;
    beat_t             held_q, held_d;
    logic              held_v_q, held_v_d;
    logic              busy_q, busy_d, done_q, done_d, err_q, err_d;

    logic       pop, rd_en, lc, legal, accept, vret, nz, mcand, flush, push;
    logic [2:0] occ;
    beat_t      mbeat, push_beat;

    always_comb begin
        pop    = (cnt_q != 2'd0) && tx.tx_ready;
        // Occupancy the FIFO will have once the outstanding read lands, net of this cycle's pop.
        occ    = {1'b0, cnt_q} + {2'b0, rv_q} - {2'b0, pop};
        rd_en  = (state_q inside {HDR, VEC, MAT}) && (occ < 3'd2);
        lc     = c_q == cols_q - 8'd1;
        legal  = (rows_cfg != 8'd0) && ({1'b0, rows_cfg} <= 9'(DIM_MAX)) &&
                 (cols_cfg != 8'd0) && ({1'b0, cols_cfg} <= 9'(DIM_MAX));
        accept = (state_q == IDLE) && start && legal;
        vret   = rv_q && !rmat_q;
        nz     = mem_rdata != 8'd0;
        // Matrix beat candidate: any non-zero, or the marker for a row that produced nothing.
        mcand  = rv_q && rmat_q && (nz || (rlc_q && !row_nz_q));
        mbeat  = beat_t'{mem_rdata, nz ? rcol_q : 8'd0, !row_nz_q, 1'b0};
        // The newest matrix beat is held back until a successor exists, so the final one can
        // carry tx_last; it is flushed once the last read has returned.
        flush  = (state_q == DRAIN) && !rv_q && held_v_q && (cnt_q != 2'd2 || pop);
        push   = accept || vret || (mcand && held_v_q) || flush;
        push_beat = accept ? beat_t'{rows_cfg, cols_cfg, 1'b0, 1'b0} :
                    vret   ? beat_t'{mem_rdata, rcol_q, 1'b0, 1'b0} :
                    flush  ? beat_t'{held_q.val, held_q.col, held_q.ipv, 1'b1} : held_q;
        fifo_d = fifo_q;
        if (push) fifo_d[wr_ptr_q] = push_beat;
        wr_ptr_d = wr_ptr_q ^ push;
        rd_ptr_d = rd_ptr_q ^ pop;
        cnt_d    = cnt_q + {1'b0, push} - {1'b0, pop};
        held_d   = mcand ? mbeat : held_q;
        held_v_d = mcand || (held_v_q && !flush);
        row_nz_d = (rv_q && rmat_q) ? (!rlc_q && (row_nz_q || nz)) : row_nz_q;
        rv_d     = rd_en;
        rmat_d   = state_q == MAT;
        rcol_d   = c_q;
        rlc_d    = lc;
        state_d  = state_q;
        rows_d   = rows_q;
        cols_d   = cols_q;
        c_d      = c_q;
        r_d      = r_q;
        base_d   = base_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        err_d    = (state_q == IDLE) && start && !legal;
        if (accept) begin
            state_d = HDR;
            rows_d  = rows_cfg;
            cols_d  = cols_cfg;
            c_d     = 8'd0;
            r_d     = 8'd0;
            base_d  = '0;
            busy_d  = 1'b1;
        end
        if (rd_en) begin
            c_d = lc ? 8'd0 : c_q + 8'd1;
            if (state_q == MAT) begin
                if (lc) begin
                    r_d    = r_q + 8'd1;
                    base_d = base_q + {{(ADDR_W-8){1'b0}}, cols_q};
                    if (r_q == rows_q - 8'd1) state_d = DRAIN;
                end
            end else begin
                state_d = lc ? MAT : VEC;
            end
        end
        if ((state_q == DRAIN) && !rv_q && !held_v_q && (cnt_d == 2'd0)) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            fifo_q[0] <= '0;
            fifo_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
            rows_q   <= 8'd0;
            cols_q   <= 8'd0;
            c_q      <= 8'd0;
            r_q      <= 8'd0;
            base_q   <= '0;
            rv_q     <= 1'b0;
            rmat_q   <= 1'b0;
            rlc_q    <= 1'b0;
            rcol_q   <= 8'd0;
            row_nz_q <= 1'b0;
            held_q   <= '0;
            held_v_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            fifo_q   <= fifo_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            rows_q   <= rows_d;
            cols_q   <= cols_d;
            c_q      <= c_d;
            r_q      <= r_d;
            base_q   <= base_d;
            rv_q     <= rv_d;
            rmat_q   <= rmat_d;
            rlc_q    <= rlc_d;
            rcol_q   <= rcol_d;
            row_nz_q <= row_nz_d;
            held_q   <= held_d;
            held_v_q <= held_v_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign mem_rd_en  = rd_en;
    assign mem_addr   = !rd_en ? '0 :
                        (state_q == MAT) ? ADDR_W'(MAT_BASE) + base_q + {{(ADDR_W-8){1'b0}}, c_q} :
                                           ADDR_W'(VEC_BASE) + {{(ADDR_W-8){1'b0}}, c_q};
    assign tx.tx_valid = cnt_q != 2'd0;
    assign tx.tx_val   = fifo_q[rd_ptr_q].val;
    assign tx.tx_col   = fifo_q[rd_ptr_q].col;
    assign tx.tx_ipv   = fifo_q[rd_ptr_q].ipv;
    assign tx.tx_last  = fifo_q[rd_ptr_q].last;
endmodule

// File: tb/tb_smvm_stream_tx.sv
// tb_smvm_stream_tx: randomized bench for smvm_stream_tx against a queue-based stream model.
module tb_smvm_stream_tx;
    localparam int MB = 128;
    typedef struct packed {
        logic [7:0] val;
        logic [7:0] col;
        logic       ipv;
        logic       last;
    } beat_t;

    logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic [7:0]  rows_cfg = 8'd0, cols_cfg = 8'd0;
    logic        busy, done, err, mem_rd_en;
    logic [14:0] mem_addr;
    logic [7:0]  mem_rdata = 8'd0;
    logic [7:0]  mem [0:32767];
    beat_t       exp_q [$];
    beat_t       cur, e, prev_beat = '0;
    logic        done_exp = 1'b0, prev_stall = 1'b0, fin;
    int          checks = 0, errors = 0, done_cnt = 0, hs_cnt = 0, cyc = 0;
    int          first_hs = -1, last_hs = -1, rand_ready = 0;

    smvm_stream_tx_if txi();

    smvm_stream_tx dut (
        .clk(clk), .rst_n(rst_n), .start(start), .rows_cfg(rows_cfg), .cols_cfg(cols_cfg),
        .busy(busy), .done(done), .err(err), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
        .mem_rdata(mem_rdata), .tx(txi.master)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_rd_en) mem_rdata <= mem[mem_addr];
    end

    initial begin
        txi.tx_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1 txi.tx_ready = (rand_ready != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, expv, $time);
        end
    endtask

    function automatic beat_t mk(input int v, input int c, input int i, input int l);
        return {8'(v), 8'(c), 1'(i), 1'(l)};
    endfunction

    // Expected stream straight from the stream rules: header, vector, then per-row non-zeros
    // (or an empty-row marker), with last set on the final beat.
    task automatic build(input int rows, input int cols);
        beat_t t;
        exp_q.push_back(mk(rows, cols, 0, 0));
        for (int i = 0; i < cols; i++) exp_q.push_back(mk(mem[i], i, 0, 0));
        for (int r = 0; r < rows; r++) begin
            int any = 0;
            for (int c = 0; c < cols; c++) begin
                int v = mem[MB + r * cols + c];
                if (v != 0) begin
                    exp_q.push_back(mk(v, c, any == 0 ? 1 : 0, 0));
                    any = 1;
                end
            end
            if (any == 0) exp_q.push_back(mk(0, 0, 1, 0));
        end
        t = exp_q.pop_back();
        t.last = 1'b1;
        exp_q.push_back(t);
    endtask

    task automatic pulse_start(input int r, input int c);
        @(posedge clk);
        #1 start = 1'b1; rows_cfg = 8'(r); cols_cfg = 8'(c);
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int d0 = done_cnt;
        int n = 0;
        while (done_cnt == d0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("done_seen", 32'(done_cnt != d0), 1);
        chk("stream_drained", exp_q.size(), 0);
        repeat (2) @(posedge clk);
    endtask

    task automatic fill(input int rows, input int cols, input int zero_pct, input int dense);
        for (int i = 0; i < cols; i++) mem[i] = 8'($urandom);
        for (int k = 0; k < rows * cols; k++)
            mem[MB + k] = (dense != 0) ? 8'($urandom_range(1, 255)) :
                          ($urandom_range(0, 99) < zero_pct) ? 8'd0 : 8'($urandom);
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
            done_exp   = 1'b0;
        end else begin
            cur = {txi.tx_val, txi.tx_col, txi.tx_ipv, txi.tx_last};
            fin = 1'b0;
            chk("done_timing", done, done_exp);
            if (done) done_cnt++;
            if (!busy) chk("read_while_idle", mem_rd_en, 0);
            if (prev_stall) begin
                chk("stall_valid", txi.tx_valid, 1);
                chk("stall_beat", cur, prev_beat);
            end
            if (txi.tx_valid && txi.tx_ready) begin
                chk("beat_expected", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("beat", cur, e);
                    fin = exp_q.size() == 0;
                end
                hs_cnt++;
                if (first_hs < 0) first_hs = cyc;
                last_hs = cyc;
            end
            prev_stall = txi.tx_valid && !txi.tx_ready;
            prev_beat  = cur;
            done_exp   = fin;
        end
    end

    initial begin
        #1500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        beat_t lit [7];
        int h0, n;
        for (int i = 0; i < 32768; i++) mem[i] = 8'd0;
        #3;
        chk("rst_outs", {busy, done, err, mem_rd_en, txi.tx_valid, txi.tx_ipv, txi.tx_last,
                         txi.tx_val, txi.tx_col}, 0);
        chk("rst_addr", mem_addr, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Worked example, model pinned to hand-computed beats.
        mem[0] = 8'd1; mem[1] = 8'd0; mem[2] = 8'hFE;
        mem[MB+0] = 8'd0; mem[MB+1] = 8'd5; mem[MB+2] = 8'd0;
        mem[MB+3] = 8'd7; mem[MB+4] = 8'd0; mem[MB+5] = 8'hFF;
        build(2, 3);
        lit[0] = mk(2, 3, 0, 0); lit[1] = mk(1, 0, 0, 0); lit[2] = mk(0, 1, 0, 0);
        lit[3] = mk(8'hFE, 2, 0, 0); lit[4] = mk(5, 1, 1, 0); lit[5] = mk(7, 0, 1, 0);
        lit[6] = mk(8'hFF, 2, 0, 1);
        chk("model_len", exp_q.size(), 7);
        for (int i = 0; i < 7; i++) chk("model_pin", exp_q[i], lit[i]);
        pulse_start(2, 3);
        chk("busy_rise", busy, 1);
        chk("hdr_valid_c1", txi.tx_valid, 1);
        chk("hdr_beat", {txi.tx_val, txi.tx_col}, 16'h0203);
        wait_done(200);

        // Row 0 all zero: marker precedes row 1.
        mem[MB+1] = 8'd0;
        build(2, 3);
        chk("model_marker", exp_q[4], mk(0, 0, 1, 0));
        chk("model_row1", exp_q[5], mk(7, 0, 1, 0));
        pulse_start(2, 3);
        wait_done(200);

        // All-zero 3x3: three markers, the last one flagged last.
        for (int k = 0; k < 9; k++) mem[MB + k] = 8'd0;
        build(3, 3);
        chk("model_zero_len", exp_q.size(), 7);
        chk("model_zero_last", exp_q[6], mk(0, 0, 1, 1));
        pulse_start(3, 3);
        wait_done(200);

        // Illegal starts: err pulse only, no activity.
        pulse_start(0, 3);
        chk("err_rows0", err, 1);
        chk("err_busy", busy, 0);
        @(posedge clk); #1;
        chk("err_pulse_len", err, 0);
        chk("err_no_read", mem_rd_en, 0);
        pulse_start(3, 200);
        chk("err_cols200", err, 1);
        chk("err_busy2", busy, 0);
        pulse_start(129, 4);
        chk("err_rows129", err, 1);
        @(posedge clk); #1;
        chk("err_idle_valid", txi.tx_valid, 0);

        // 16x16 sparse, ready=1, with an ignored start while busy.
        fill(16, 16, 50, 0);
        build(16, 16);
        pulse_start(16, 16);
        repeat (4) @(posedge clk);
        pulse_start(1, 1);
        chk("busy_start_no_err", err, 0);
        chk("busy_start_busy", busy, 1);
        wait_done(2000);

        // Same data, random back-pressure.
        rand_ready = 1;
        build(16, 16);
        pulse_start(16, 16);
        wait_done(4000);

        // Reset in the matrix phase, then a fresh full command.
        build(16, 16);
        h0 = hs_cnt;
        pulse_start(16, 16);
        n = 0;
        while (hs_cnt - h0 < 40 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("reach_mat", 32'(hs_cnt - h0 >= 40), 1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_outs", {busy, done, err, mem_rd_en, txi.tx_valid, txi.tx_ipv, txi.tx_last,
                            txi.tx_val, txi.tx_col}, 0);
        chk("midrst_addr", mem_addr, 0);
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        build(16, 16);
        pulse_start(16, 16);
        chk("fresh_hdr", {txi.tx_valid, txi.tx_val, txi.tx_col}, {1'b1, 16'h1010});
        wait_done(4000);

        // Small random commands under back-pressure.
        for (int t = 0; t < 4; t++) begin
            int r = $urandom_range(1, 8);
            int c = $urandom_range(1, 8);
            fill(r, c, 60, 0);
            build(r, c);
            pulse_start(r, c);
            wait_done(1000);
        end

        // 128x128 dense at full rate.
        rand_ready = 0;
        repeat (2) @(posedge clk);
        fill(128, 128, 0, 1);
        build(128, 128);
        chk("model_dense_len", exp_q.size(), 1 + 128 + 16384);
        first_hs = -1;
        h0 = hs_cnt;
        pulse_start(128, 128);
        wait_done(20000);
        chk("dense_beats", hs_cnt - h0, 1 + 128 + 16384);
        chk("dense_rate", 32'(last_hs - first_hs + 1 <= 1 + 128 + 16384 + 3), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
